// File: rtl/rob_pkg.sv
// Shared constants, types and helpers for the reorder buffer.
// Tags are ROB_ADD_W wide; tag 0 means "no dependency", so usable slots are 1..ROB_S-1.
// Store opcodes identify which LSB-bound instructions need a store commit.
package rob_pkg;

  localparam int ROB_ADD_W = 4;
  localparam int ROB_S     = 1 << ROB_ADD_W;  // entry 0 exists but is never issued
  localparam int REG_DAT_W = 32;
  localparam int REG_ADD_W = 5;
  localparam int INS_OP_W  = 6;
  localparam int FULL_THR  = ROB_S - 2;       // one slot of slack for the reservation in flight

  typedef logic [ROB_ADD_W-1:0] tag_t;
  typedef logic [ROB_ADD_W:0]   cnt_t;
  typedef logic [REG_DAT_W-1:0] dat_t;
  typedef logic [REG_ADD_W-1:0] reg_t;
  typedef logic [INS_OP_W-1:0]  op_t;

  localparam op_t OP_SB = 6'h28;
  localparam op_t OP_SH = 6'h29;
  localparam op_t OP_SW = 6'h2b;

  typedef struct packed {
    logic busy;
    logic ready;
    reg_t rd;
    dat_t value;
    logic mp;
    dat_t npc;
    logic is_store;
  } slot_t;

  // Dispatch payload shared by the RS and LSB strobes
  typedef struct packed {
    tag_t qs1;
    tag_t qs2;
    tag_t qd;
    dat_t vs1;
    dat_t vs2;
    dat_t pc;
    dat_t imm;
    op_t  op;
  } dp_t;

  // Commit payload toward the register file / LSB
  typedef struct packed {
    reg_t rd;
    tag_t qd;
    dat_t vd;
  } cm_t;

  // Circular advance over 1..ROB_S-1, skipping tag 0
  function automatic tag_t next_tag(input tag_t t);
    return (t == tag_t'(ROB_S - 1)) ? tag_t'(1) : t + tag_t'(1);
  endfunction

  function automatic logic is_store_op(input op_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/rob_if.sv
// Reorder-buffer bus bundle: issue, rename, dispatch, CDB, commit and flush signals.
// slave = the ROB itself (consumes i*, drives o*); master = the surrounding pipeline.
// Port names keep the pipeline-wide i*/o* naming so they line up with the neighbouring stages.
interface rob_if;
  import rob_pkg::*;

  logic iIS_En;
  tag_t oRF_Qn;
  logic oIS_Full;

  logic iRF_En;
  tag_t iRF_Qd;
  reg_t iRF_Rd;
  tag_t iRF_Qs1, iRF_Qs2;
  dat_t iRF_Vs1, iRF_Vs2;
  op_t  iRF_Op;
  dat_t iRF_Pc, iRF_Imm;
  logic iRF_Ils;

  logic oRS_En, oLSB_En;
  tag_t oDP_Qs1, oDP_Qs2, oDP_Qd;
  dat_t oDP_Vs1, oDP_Vs2, oDP_Pc, oDP_Imm;
  op_t  oDP_Op;

  logic iCDB_En;
  tag_t iCDB_Q;
  dat_t iCDB_V;
  logic iCDB_Mp;
  dat_t iCDB_Npc;

  logic oRF_En;
  reg_t oRF_Rd;
  tag_t oRF_Qd;
  dat_t oRF_Vd;
  logic oLSB_Cmt;
  tag_t oLSB_CmtQ;
  logic oMp;
  dat_t oMpPc;

  modport slave (
    input  iIS_En, iRF_En, iRF_Qd, iRF_Rd, iRF_Qs1, iRF_Qs2, iRF_Vs1, iRF_Vs2,
           iRF_Op, iRF_Pc, iRF_Imm, iRF_Ils, iCDB_En, iCDB_Q, iCDB_V, iCDB_Mp, iCDB_Npc,
    output oRF_Qn, oIS_Full, oRS_En, oLSB_En, oDP_Qs1, oDP_Qs2, oDP_Qd, oDP_Vs1,
           oDP_Vs2, oDP_Pc, oDP_Imm, oDP_Op, oRF_En, oRF_Rd, oRF_Qd, oRF_Vd,
           oLSB_Cmt, oLSB_CmtQ, oMp, oMpPc
  );

  modport master (
    output iIS_En, iRF_En, iRF_Qd, iRF_Rd, iRF_Qs1, iRF_Qs2, iRF_Vs1, iRF_Vs2,
           iRF_Op, iRF_Pc, iRF_Imm, iRF_Ils, iCDB_En, iCDB_Q, iCDB_V, iCDB_Mp, iCDB_Npc,
    input  oRF_Qn, oIS_Full, oRS_En, oLSB_En, oDP_Qs1, oDP_Qs2, oDP_Qd, oDP_Vs1,
           oDP_Vs2, oDP_Pc, oDP_Imm, oDP_Op, oRF_En, oRF_Rd, oRF_Qd, oRF_Vd,
           oLSB_Cmt, oLSB_CmtQ, oMp, oMpPc
  );

endinterface

// File: rtl/rob_fwd.sv
// Operand forwarding for one source: resolves a stale tag from the CDB or the ROB slot.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Ports: qs/vs incoming operand, cdb_* live broadcast, slot_* state of slot qs, q_o/v_o result.
module rob_fwd
  import rob_pkg::*;
(
  input  tag_t qs,
  input  dat_t vs,
  input  logic cdb_en,
  input  tag_t cdb_q,
  input  dat_t cdb_v,
  input  logic slot_busy,
  input  logic slot_ready,
  input  dat_t slot_val,
  output tag_t q_o,
  output dat_t v_o
);

  always_comb begin
    q_o = qs;
    v_o = vs;
    if (qs != '0) begin
      if (cdb_en && (cdb_q == qs)) begin
        q_o = '0;
        v_o = cdb_v;
      end else if (slot_ready || !slot_busy) begin
        // A non-busy slot has already committed; its value is still held in the slot
        q_o = '0;
        v_o = slot_val;
      end
    end
  end

endmodule

// File: rtl/rob.sv
// Reorder buffer: tag reservation, operand forwarding/dispatch, CDB capture, in-order commit, flush.
// Latency: dispatch 1 cycle after iRF_En; commit >= 1 cycle after CDB capture; oMp with the faulting commit.
// Backpressure: oIS_Full when 14+ tags are held; en=0 freezes all state; inputs ignored while oMp=1.
// Ports: clk, rst (sync, active-high), en, io (rob_if.slave).
// Optional: define ROB_TRACE_EN to print each commit and count commits in simulation.
module rob
  import rob_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  rob_if.slave io
);

  slot_t slots_q [ROB_S];
  slot_t slots_d [ROB_S];
  tag_t  alloc_q, alloc_d, head_q, head_d;
  cnt_t  cnt_q, cnt_d;
  dp_t   dp_q, dp_d;
  cm_t   cm_q, cm_d;
  logic  rs_en_q, rs_en_d, lsb_en_q, lsb_en_d;
  logic  rf_en_q, rf_en_d, lsb_cmt_q, lsb_cmt_d;
  logic  mp_q, mp_d;
  dat_t  mp_pc_q, mp_pc_d;

  logic  live, res, alc, cdb, cmt, flush;
  slot_t hd;
  tag_t  fq1, fq2;
  dat_t  fv1, fv2;

  // The flush cycle swallows all pipeline inputs
  assign live  = en && !mp_q;
  assign res   = live && io.iIS_En;
  assign alc   = live && io.iRF_En;
  assign cdb   = live && io.iCDB_En && slots_q[io.iCDB_Q].busy;
  assign hd    = slots_q[head_q];
  assign cmt   = en && hd.busy && hd.ready;
  assign flush = cmt && hd.mp;

  rob_fwd u_fwd1 (
    .qs(io.iRF_Qs1), .vs(io.iRF_Vs1),
    .cdb_en(live && io.iCDB_En), .cdb_q(io.iCDB_Q), .cdb_v(io.iCDB_V),
    .slot_busy(slots_q[io.iRF_Qs1].busy), .slot_ready(slots_q[io.iRF_Qs1].ready),
    .slot_val(slots_q[io.iRF_Qs1].value), .q_o(fq1), .v_o(fv1)
  );

  rob_fwd u_fwd2 (
    .qs(io.iRF_Qs2), .vs(io.iRF_Vs2),
    .cdb_en(live && io.iCDB_En), .cdb_q(io.iCDB_Q), .cdb_v(io.iCDB_V),
    .slot_busy(slots_q[io.iRF_Qs2].busy), .slot_ready(slots_q[io.iRF_Qs2].ready),
    .slot_val(slots_q[io.iRF_Qs2].value), .q_o(fq2), .v_o(fv2)
  );

  always_comb begin
    slots_d   = slots_q;
    alloc_d   = alloc_q;
    head_d    = head_q;
    dp_d      = dp_q;
    cm_d      = cm_q;
    mp_pc_d   = mp_pc_q;
    // Strobes are single-cycle pulses, but hold along with everything else when en=0
    rs_en_d   = en ? 1'b0 : rs_en_q;
    lsb_en_d  = en ? 1'b0 : lsb_en_q;
    rf_en_d   = en ? 1'b0 : rf_en_q;
    lsb_cmt_d = en ? 1'b0 : lsb_cmt_q;
    mp_d      = en ? 1'b0 : mp_q;

    if (alc) begin
      slots_d[io.iRF_Qd].busy     = 1'b1;
      slots_d[io.iRF_Qd].ready    = 1'b0;
      slots_d[io.iRF_Qd].mp       = 1'b0;
      slots_d[io.iRF_Qd].rd       = io.iRF_Rd;
      slots_d[io.iRF_Qd].is_store = io.iRF_Ils && is_store_op(io.iRF_Op);
      rs_en_d  = !io.iRF_Ils;
      lsb_en_d = io.iRF_Ils;
      dp_d = '{qs1: fq1, qs2: fq2, qd: io.iRF_Qd, vs1: fv1, vs2: fv2,
               pc: io.iRF_Pc, imm: io.iRF_Imm, op: io.iRF_Op};
    end

    if (cdb) begin
      slots_d[io.iCDB_Q].ready = 1'b1;
      slots_d[io.iCDB_Q].value = io.iCDB_V;
      slots_d[io.iCDB_Q].mp    = io.iCDB_Mp;
      slots_d[io.iCDB_Q].npc   = io.iCDB_Npc;
    end

    if (res) alloc_d = next_tag(alloc_q);

    if (cmt) begin
      slots_d[head_q].busy = 1'b0;  // value is deliberately left in place
      head_d    = next_tag(head_q);
      rf_en_d   = 1'b1;
      lsb_cmt_d = hd.is_store;
      cm_d      = '{rd: hd.rd, qd: head_q, vd: hd.value};
    end

    cnt_d = cnt_q + cnt_t'(res) - cnt_t'(cmt);

    // Mispredicted commit: the commit itself stands, everything younger is dropped
    if (flush) begin
      for (int i = 0; i < ROB_S; i++) begin
        slots_d[i].busy  = 1'b0;
        slots_d[i].ready = 1'b0;
      end
      alloc_d  = tag_t'(1);
      head_d   = tag_t'(1);
      cnt_d    = '0;
      rs_en_d  = 1'b0;
      lsb_en_d = 1'b0;
      mp_d     = 1'b1;
      mp_pc_d  = hd.npc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_S; i++) slots_q[i] <= '0;
      alloc_q   <= tag_t'(1);
      head_q    <= tag_t'(1);
      cnt_q     <= '0;
      dp_q      <= '0;
      cm_q      <= '0;
      rs_en_q   <= 1'b0;
      lsb_en_q  <= 1'b0;
      rf_en_q   <= 1'b0;
      lsb_cmt_q <= 1'b0;
      mp_q      <= 1'b0;
      mp_pc_q   <= '0;
    end else begin
      slots_q   <= slots_d;
      alloc_q   <= alloc_d;
      head_q    <= head_d;
      cnt_q     <= cnt_d;
      dp_q      <= dp_d;
      cm_q      <= cm_d;
      rs_en_q   <= rs_en_d;
      lsb_en_q  <= lsb_en_d;
      rf_en_q   <= rf_en_d;
      lsb_cmt_q <= lsb_cmt_d;
      mp_q      <= mp_d;
      mp_pc_q   <= mp_pc_d;
    end
  end

  assign io.oRF_Qn    = alloc_q;
  assign io.oIS_Full  = (cnt_q >= cnt_t'(FULL_THR));
  assign io.oRS_En    = rs_en_q;
  assign io.oLSB_En   = lsb_en_q;
  assign io.oDP_Qs1   = dp_q.qs1;
  assign io.oDP_Qs2   = dp_q.qs2;
  assign io.oDP_Qd    = dp_q.qd;
  assign io.oDP_Vs1   = dp_q.vs1;
  assign io.oDP_Vs2   = dp_q.vs2;
  assign io.oDP_Pc    = dp_q.pc;
  assign io.oDP_Imm   = dp_q.imm;
  assign io.oDP_Op    = dp_q.op;
  assign io.oRF_En    = rf_en_q;
  assign io.oRF_Rd    = cm_q.rd;
  assign io.oRF_Qd    = cm_q.qd;
  assign io.oRF_Vd    = cm_q.vd;
  assign io.oLSB_Cmt  = lsb_cmt_q;
  assign io.oLSB_CmtQ = cm_q.qd;
  assign io.oMp       = mp_q;
  assign io.oMpPc     = mp_pc_q;

`ifdef ROB_TRACE_EN
  logic [31:0] cmt_cnt_q, cmt_cnt_d;
  assign cmt_cnt_d = cmt ? cmt_cnt_q + 32'd1 : cmt_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cmt_cnt_q <= '0;
    end else begin
      cmt_cnt_q <= cmt_cnt_d;
      if (cmt) $display("[rob] commit #%0d tag=%0d rd=%0d value=%08h",
                        cmt_cnt_d, head_q, hd.rd, hd.value);
    end
  end
`endif

endmodule
